// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, fetch FSM
// encodings and the instruction field positions the decoder also uses.
package ifu_fetch_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } ifu_state_e;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC selection for the fetch PC register: a redirect beats sequential
// advance, otherwise the PC holds.
module ifu_pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (advance) begin
      pc_next = pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding word read at a
// time and hands each instruction to decode over a valid/ready handshake.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            drop;
  logic            req_fire;
  logic            advance;
  logic            vld_p1;
  logic [31:0]     inst_p1;
  logic [XLEN-1:0] inst_pc_p1;

  assign imem_req_valid = (state == ST_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign advance        = (state == ST_HOLD) && inst_ready;

  ifu_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .pc_next        (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      vld_p1     <= 1'b0;
      inst_p1    <= '0;
      inst_pc_p1 <= '0;
    end else begin
      pc <= pc_next;
      case (state)
        ST_REQ: begin
          // A redirect racing an accepted request means that fetch is stale.
          if (req_fire) begin
            state <= ST_WAIT;
            drop  <= redirect_valid;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop || redirect_valid) begin
              state <= ST_REQ;
              drop  <= 1'b0;
            end else begin
              state      <= ST_HOLD;
              vld_p1     <= 1'b1;
              inst_p1    <= imem_rsp_data;
              inst_pc_p1 <= pc;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid || inst_ready) begin
            state  <= ST_REQ;
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state  <= ST_REQ;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  // Decode-facing stage: registered instruction and its pre-split fields
  assign inst_valid = vld_p1;
  assign inst       = inst_p1;
  assign inst_pc    = inst_pc_p1;
  assign opcode     = inst_p1[OPCODE_MSB:OPCODE_LSB];
  assign funct3     = inst_p1[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7     = inst_p1[FUNCT7_MSB:FUNCT7_LSB];

endmodule
